// File: rtl/mem_wb_stage.sv
// MEM stage plus MEM/WB pipeline register with a multi-cycle data-memory access.
// Optional feature macro: MISALIGN_TRAP_EN (sticky trap on misaligned memory accesses).
module mem_wb_stage #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [1:0]  WB_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] write_data_i,
    input  logic [4:0]  RegDst_i,
    output logic [1:0]  WB_o,
    output logic [31:0] mem_data_o,
    output logic [31:0] alu_data_o,
    output logic [4:0]  RegDst_o,
    output logic        stall_o,
    output logic        misalign_o
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((LATENCY > 1) ? LATENCY - 2 : 0);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         reqWb_q, reqWb_d;
    logic [31:0]        reqAddr_q, reqAddr_d;
    logic [31:0]        reqData_q, reqData_d;
    logic [4:0]         reqRegDst_q, reqRegDst_d;
    logic               reqWrite_q, reqWrite_d;
    logic [1:0]         wb_q, wb_d;
    logic [31:0]        memData_q, memData_d;
    logic [31:0]        aluData_q, aluData_d;
    logic [4:0]         regDst_q, regDst_d;
    logic               misalign_q, misalign_d;

    logic [31:0]        mem [DEPTH_WORDS];
    logic               memOp;
    logic               misaligned;
    logic               memWe;
    logic               stallComb;
    logic [IDX_W-1:0]   accIdx;
    logic [31:0]        memWdata;
    logic [31:0]        rdData;

    assign memOp = MemRead_i | MemWrite_i;

`ifdef MISALIGN_TRAP_EN
    assign misaligned = memOp && (addr_i[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    // The completing BUSY cycle uses the latched request; upstream inputs are stale then.
    assign accIdx   = (state_q == BUSY) ? reqAddr_q[IDX_W+1:2] : addr_i[IDX_W+1:2];
    assign memWdata = (state_q == BUSY) ? reqData_q : write_data_i;
    assign rdData   = mem[accIdx];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        reqWb_d     = reqWb_q;
        reqAddr_d   = reqAddr_q;
        reqData_d   = reqData_q;
        reqRegDst_d = reqRegDst_q;
        reqWrite_d  = reqWrite_q;
        wb_d        = wb_q;
        memData_d   = memData_q;
        aluData_d   = aluData_q;
        regDst_d    = regDst_q;
        misalign_d  = misalign_q;
        memWe       = 1'b0;
        stallComb   = 1'b0;

        case (state_q)
            IDLE: begin
                if (!memOp) begin
                    wb_d      = WB_i;
                    aluData_d = addr_i;
                    regDst_d  = RegDst_i;
                end else if (misaligned) begin
                    wb_d       = 2'b00;
                    memData_d  = 32'h0;
                    aluData_d  = addr_i;
                    regDst_d   = RegDst_i;
                    misalign_d = 1'b1;
                end else if (LATENCY == 1) begin
                    memWe     = MemWrite_i;
                    memData_d = rdData;
                    wb_d      = WB_i;
                    aluData_d = addr_i;
                    regDst_d  = RegDst_i;
                end else begin
                    stallComb   = 1'b1;
                    reqWb_d     = WB_i;
                    reqAddr_d   = addr_i;
                    reqData_d   = write_data_i;
                    reqRegDst_d = RegDst_i;
                    reqWrite_d  = MemWrite_i;
                    cnt_d       = CNT_INIT;
                    state_d     = BUSY;
                    wb_d        = 2'b00;
                    regDst_d    = 5'd0;
                end
            end
            BUSY: begin
                if (cnt_q != '0) begin
                    stallComb = 1'b1;
                    cnt_d     = cnt_q - CNT_W'(1);
                    wb_d      = 2'b00;
                    regDst_d  = 5'd0;
                end else begin
                    memWe     = reqWrite_q;
                    memData_d = rdData;
                    wb_d      = reqWb_q;
                    aluData_d = reqAddr_q;
                    regDst_d  = reqRegDst_q;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign stall_o = stallComb & ~rst_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            reqWb_q     <= 2'b00;
            reqAddr_q   <= 32'h0;
            reqData_q   <= 32'h0;
            reqRegDst_q <= 5'd0;
            reqWrite_q  <= 1'b0;
            wb_q        <= 2'b00;
            memData_q   <= 32'h0;
            aluData_q   <= 32'h0;
            regDst_q    <= 5'd0;
            misalign_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            reqWb_q     <= reqWb_d;
            reqAddr_q   <= reqAddr_d;
            reqData_q   <= reqData_d;
            reqRegDst_q <= reqRegDst_d;
            reqWrite_q  <= reqWrite_d;
            wb_q        <= wb_d;
            memData_q   <= memData_d;
            aluData_q   <= aluData_d;
            regDst_q    <= regDst_d;
            misalign_q  <= misalign_d;
        end
    end

    // Array is deliberately not reset; a held reset must still block any write.
    always_ff @(posedge clk_i) begin
        if (memWe && !rst_i) begin
            mem[accIdx] <= memWdata;
        end
    end

    assign WB_o       = wb_q;
    assign mem_data_o = memData_q;
    assign alu_data_o = aluData_q;
    assign RegDst_o   = regDst_q;
    assign misalign_o = misalign_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: a LATENCY=2 instance plus a LATENCY=4 instance for abort checks.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  wbIn = 2'b00;
    logic        memRead = 1'b0;
    logic        memWrite = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic [4:0]  regDstIn = 5'd0;

    logic [1:0]  wbOut, wbOut4;
    logic [31:0] memData, memData4;
    logic [31:0] aluData, aluData4;
    logic [4:0]  regDstOut, regDstOut4;
    logic        stall, stall4;
    logic        misalign, misalign4;

    int checks = 0;
    int passed = 0;

    mem_wb_stage #(.DEPTH_WORDS(256), .LATENCY(2)) dut (
        .clk_i(clk), .rst_i(rst), .WB_i(wbIn), .MemRead_i(memRead), .MemWrite_i(memWrite),
        .addr_i(addr), .write_data_i(wdata), .RegDst_i(regDstIn),
        .WB_o(wbOut), .mem_data_o(memData), .alu_data_o(aluData), .RegDst_o(regDstOut),
        .stall_o(stall), .misalign_o(misalign)
    );

    mem_wb_stage #(.DEPTH_WORDS(256), .LATENCY(4)) dut4 (
        .clk_i(clk), .rst_i(rst), .WB_i(wbIn), .MemRead_i(memRead), .MemWrite_i(memWrite),
        .addr_i(addr), .write_data_i(wdata), .RegDst_i(regDstIn),
        .WB_o(wbOut4), .mem_data_o(memData4), .alu_data_o(aluData4), .RegDst_o(regDstOut4),
        .stall_o(stall4), .misalign_o(misalign4)
    );

    always #5 clk = ~clk;

    // Called just after a posedge; returns just after the completing posedge.
    task automatic doMemOp(input bit use4, input logic rdReq, input logic wrReq,
                           input logic [31:0] a, input logic [31:0] d,
                           input logic [1:0] wb, input logic [4:0] rdst,
                           output int stalls, output bit bubbleBad, output bit timedOut);
        memRead = rdReq; memWrite = wrReq; addr = a; wdata = d; wbIn = wb; regDstIn = rdst;
        stalls = 0; bubbleBad = 1'b0; timedOut = 1'b1;
        for (int i = 0; i < 16; i++) begin
            #1;
            if ((use4 ? stall4 : stall) === 1'b1) begin
                stalls++;
                @(posedge clk); #1;
                if (use4 ? (wbOut4 !== 2'b00 || regDstOut4 !== 5'd0)
                         : (wbOut !== 2'b00 || regDstOut !== 5'd0)) bubbleBad = 1'b1;
            end else begin
                @(posedge clk); #1;
                timedOut = 1'b0;
                break;
            end
        end
        memRead = 1'b0; memWrite = 1'b0;
    endtask

    task automatic nopCycle();
        memRead = 1'b0; memWrite = 1'b0; wbIn = 2'b00; regDstIn = 5'd0; addr = 32'h0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        @(posedge clk); #2; rst = 1'b0;
        @(posedge clk); #1;
        wbIn = 2'b10; addr = 32'hABC; regDstIn = 5'd3;
        @(posedge clk); #1;
        memRead = 1'b1; addr = 32'h10;
        #1;
        checks++; if (stall !== 1'b1) $display("[TB] FAIL reset_pre_stall: got %b expected 1", stall); else passed++;
        #1 rst = 1'b1;
        #1;
        checks++; if (wbOut !== 2'b00) $display("[TB] FAIL reset_wb: got %b expected 00", wbOut); else passed++;
        checks++; if (aluData !== 32'h0) $display("[TB] FAIL reset_alu: got %h expected 0", aluData); else passed++;
        checks++; if (regDstOut !== 5'd0) $display("[TB] FAIL reset_regdst: got %0d expected 0", regDstOut); else passed++;
        checks++; if (memData !== 32'h0) $display("[TB] FAIL reset_memdata: got %h expected 0", memData); else passed++;
        checks++; if (stall !== 1'b0) $display("[TB] FAIL reset_stall: got %b expected 0", stall); else passed++;
        checks++; if (misalign !== 1'b0) $display("[TB] FAIL reset_misalign: got %b expected 0", misalign); else passed++;
        memRead = 1'b0; wbIn = 2'b00; regDstIn = 5'd0; addr = 32'h0;
        @(posedge clk); #2; rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_store_load();
        int s; bit bb; bit to;
        doMemOp(1'b0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 2'b00, 5'd0, s, bb, to);
        checks++; if (to || s != 1) $display("[TB] FAIL store_stalls: got %0d expected 1 (timeout=%0b)", s, to); else passed++;
        checks++; if (bb) $display("[TB] FAIL store_bubble: got nonzero WB/RegDst expected 0"); else passed++;
        doMemOp(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 2'b11, 5'd7, s, bb, to);
        checks++; if (to || s != 1) $display("[TB] FAIL load_stalls: got %0d expected 1 (timeout=%0b)", s, to); else passed++;
        checks++; if (memData !== 32'hDEADBEEF) $display("[TB] FAIL load_data: got %h expected deadbeef", memData); else passed++;
        checks++; if (wbOut !== 2'b11) $display("[TB] FAIL load_wb: got %b expected 11", wbOut); else passed++;
        checks++; if (regDstOut !== 5'd7) $display("[TB] FAIL load_regdst: got %0d expected 7", regDstOut); else passed++;
        checks++; if (aluData !== 32'h10) $display("[TB] FAIL load_alu: got %h expected 10", aluData); else passed++;
        nopCycle();
    endtask

    task automatic test_alu();
        memRead = 1'b0; memWrite = 1'b0; wbIn = 2'b10; addr = 32'h1234; regDstIn = 5'd5;
        #1;
        checks++; if (stall !== 1'b0) $display("[TB] FAIL alu_stall: got %b expected 0", stall); else passed++;
        @(posedge clk); #1;
        checks++; if (aluData !== 32'h1234) $display("[TB] FAIL alu_data: got %h expected 1234", aluData); else passed++;
        checks++; if (wbOut !== 2'b10) $display("[TB] FAIL alu_wb: got %b expected 10", wbOut); else passed++;
        checks++; if (regDstOut !== 5'd5) $display("[TB] FAIL alu_regdst: got %0d expected 5", regDstOut); else passed++;
        checks++; if (memData !== 32'hDEADBEEF) $display("[TB] FAIL alu_memhold: got %h expected deadbeef", memData); else passed++;
        nopCycle();
    endtask

    task automatic test_back_to_back();
        int s; bit bb; bit to;
        doMemOp(1'b0, 1'b0, 1'b1, 32'h400, 32'h55, 2'b00, 5'd0, s, bb, to);
        checks++; if (to || s != 1) $display("[TB] FAIL wrap_store_stalls: got %0d expected 1", s); else passed++;
        doMemOp(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 2'b11, 5'd9, s, bb, to);
        checks++; if (to || s != 1) $display("[TB] FAIL b2b_load0_stalls: got %0d expected 1", s); else passed++;
        checks++; if (memData !== 32'h55) $display("[TB] FAIL wrap_load: got %h expected 55", memData); else passed++;
        doMemOp(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 2'b11, 5'd10, s, bb, to);
        checks++; if (to || s != 1) $display("[TB] FAIL b2b_load1_stalls: got %0d expected 1", s); else passed++;
        checks++; if (memData !== 32'hDEADBEEF || regDstOut !== 5'd10)
            $display("[TB] FAIL b2b_load1: got %h/%0d expected deadbeef/10", memData, regDstOut); else passed++;
        nopCycle();
    endtask

    task automatic test_misalign();
        int s; bit bb; bit to;
        doMemOp(1'b0, 1'b0, 1'b1, 32'h13, 32'h77, 2'b11, 5'd4, s, bb, to);
`ifdef MISALIGN_TRAP_EN
        checks++; if (to || s != 0) $display("[TB] FAIL mis_stalls: got %0d expected 0", s); else passed++;
        checks++; if (wbOut !== 2'b00) $display("[TB] FAIL mis_wb: got %b expected 00", wbOut); else passed++;
        checks++; if (misalign !== 1'b1) $display("[TB] FAIL mis_flag: got %b expected 1", misalign); else passed++;
        doMemOp(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 2'b11, 5'd4, s, bb, to);
        checks++; if (memData !== 32'hDEADBEEF) $display("[TB] FAIL mis_mem4: got %h expected deadbeef", memData); else passed++;
        nopCycle();
        checks++; if (misalign !== 1'b1) $display("[TB] FAIL mis_sticky: got %b expected 1", misalign); else passed++;
`else
        checks++; if (to || s != 1) $display("[TB] FAIL unaligned_stalls: got %0d expected 1", s); else passed++;
        checks++; if (misalign !== 1'b0) $display("[TB] FAIL unaligned_flag: got %b expected 0", misalign); else passed++;
        doMemOp(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 2'b11, 5'd4, s, bb, to);
        checks++; if (memData !== 32'h77) $display("[TB] FAIL unaligned_mem4: got %h expected 77", memData); else passed++;
        nopCycle();
`endif
    endtask

    task automatic test_abort();
        int s; bit bb; bit to; bit sawStall;
        rst = 1'b1; #1;
        @(posedge clk); #2; rst = 1'b0;
        @(posedge clk); #1;
        doMemOp(1'b1, 1'b0, 1'b1, 32'h20, 32'h11111111, 2'b00, 5'd0, s, bb, to);
        checks++; if (to || s != 3) $display("[TB] FAIL l4_store_stalls: got %0d expected 3", s); else passed++;
        checks++; if (bb) $display("[TB] FAIL l4_bubble: got nonzero WB/RegDst expected 0"); else passed++;
        memWrite = 1'b1; addr = 32'h20; wdata = 32'h22222222; wbIn = 2'b00;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++; if (stall4 !== 1'b1) $display("[TB] FAIL l4_busy2_stall: got %b expected 1", stall4); else passed++;
        rst = 1'b1; #1;
        checks++; if (stall4 !== 1'b0) $display("[TB] FAIL l4_abort_stall: got %b expected 0", stall4); else passed++;
        checks++; if (aluData4 !== 32'h0 || wbOut4 !== 2'b00)
            $display("[TB] FAIL l4_abort_outs: got %h/%b expected 0/00", aluData4, wbOut4); else passed++;
        memWrite = 1'b0; addr = 32'h44; wdata = 32'h0; wbIn = 2'b10; regDstIn = 5'd2;
        @(posedge clk); #2; rst = 1'b0;
        sawStall = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (stall4 !== 1'b0) sawStall = 1'b1;
        end
        checks++; if (sawStall) $display("[TB] FAIL l4_idle_after_abort: got stall expected none"); else passed++;
        doMemOp(1'b1, 1'b1, 1'b0, 32'h20, 32'h0, 2'b11, 5'd6, s, bb, to);
        checks++; if (to || s != 3) $display("[TB] FAIL l4_load_stalls: got %0d expected 3", s); else passed++;
        checks++; if (memData4 !== 32'h11111111) $display("[TB] FAIL l4_no_write: got %h expected 11111111", memData4); else passed++;
        checks++; if (wbOut4 !== 2'b11) $display("[TB] FAIL l4_load_wb: got %b expected 11", wbOut4); else passed++;
        nopCycle();
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_alu();
        test_back_to_back();
        test_misalign();
        test_abort();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
